// File: rtl/cpu_pkg.sv
// Shared types, constants and instruction-field helpers for the 16-bit multi-cycle CPU.
package cpu_pkg;

  localparam logic [15:0] HALT_WORD = 16'hFFFF;

  typedef enum logic [3:0] {
    OpNop  = 4'h0,
    OpAdd  = 4'h1,
    OpSub  = 4'h2,
    OpAnd  = 4'h3,
    OpOr   = 4'h4,
    OpAddi = 4'h5,
    OpLd   = 4'h9,
    OpSt   = 4'hA,
    OpBeq  = 4'hC,
    OpBgt  = 4'hD,
    OpJmp  = 4'hE,
    OpHalt = 4'hF
  } opcode_e;

  typedef enum logic [2:0] {StFetch, StDecode, StExec, StMem, StWb, StHalted} state_e;

  function automatic opcode_e f_op(input logic [15:0] w);
    return opcode_e'(w[15:12]);
  endfunction

  function automatic logic [3:0] f_a(input logic [15:0] w);
    return w[11:8];
  endfunction

  function automatic logic [3:0] f_b(input logic [15:0] w);
    return w[7:4];
  endfunction

  function automatic logic [3:0] f_c(input logic [15:0] w);
    return w[3:0];
  endfunction

  function automatic logic [7:0] f_imm8(input logic [15:0] w);
    return w[7:0];
  endfunction

  function automatic logic [15:0] sext8(input logic [7:0] v);
    return {{8{v[7]}}, v};
  endfunction

  function automatic logic [7:0] sext4(input logic [3:0] v);
    return {{4{v[3]}}, v};
  endfunction

endpackage

// File: rtl/decode_module.sv
// Sixteen-entry register file; operand latches are loaded during DECODE.
module decode_module (
  input  logic        clk,
  input  logic        rst,
  input  logic        decode_en,
  input  logic [3:0]  ra,
  input  logic [3:0]  rb,
  input  logic [3:0]  rc,
  input  logic        we,
  input  logic [3:0]  waddr,
  input  logic [15:0] wdata,
  output logic [15:0] a_val,
  output logic [15:0] b_val,
  output logic [15:0] c_val,
  output logic [15:0] r1
);

  logic [15:0] regs [16];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) regs[i] <= '0;
      a_val <= '0;
      b_val <= '0;
      c_val <= '0;
    end else begin
      if (we) regs[waddr] <= wdata;
      if (decode_en) begin
        a_val <= regs[ra];
        b_val <= regs[rb];
        c_val <= regs[rc];
      end
    end
  end

  assign r1 = regs[1];

endmodule

// File: rtl/fetch_module.sv
// Program counter and instruction ROM; latches the addressed word during FETCH.
module fetch_module #(
  parameter int unsigned IMEM_DEPTH = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_en,
  input  logic        pc_we,
  input  logic [7:0]  pc_next,
  input  logic        prog_we,
  input  logic [7:0]  prog_addr,
  input  logic [15:0] prog_data,
  output logic [7:0]  pc,
  output logic [15:0] instr
);

  logic [15:0] memory [IMEM_DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc    <= '0;
      instr <= '0;
    end else begin
      if (pc_we)    pc    <= pc_next;
      if (fetch_en) instr <= memory[pc];
    end
  end

  // Board-side load port; the top ties it off and the ROM is preloaded hierarchically.
  always_ff @(posedge clk) begin
    if (prog_we) memory[prog_addr] <= prog_data;
  end

endmodule

// File: rtl/memory_module.sv
// Data RAM with synchronous write and registered read; contents survive reset.
module memory_module #(
  parameter int unsigned DMEM_DEPTH = 256
) (
  input  logic        clk,
  input  logic        mem_en,
  input  logic        we,
  input  logic [7:0]  addr,
  input  logic [15:0] wdata,
  output logic [15:0] rdata
);

  logic [15:0] memory [DMEM_DEPTH];

  always_ff @(posedge clk) begin
    if (mem_en) begin
      if (we) memory[addr] <= wdata;
      rdata <= memory[addr];
    end
  end

endmodule

// File: rtl/seg7_driver.sv
// Four-digit multiplexed hex display; active-low segments and digit selects.
module seg7_driver #(
  parameter int unsigned SCAN_BITS = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] value,
  output logic [7:0]  seg,
  output logic [3:0]  sel
);

  logic [SCAN_BITS+1:0] cnt;
  logic [1:0]           digit;
  logic [3:0]           nib;
  logic [7:0]           font;

  assign digit = cnt[SCAN_BITS+1:SCAN_BITS];
  assign nib   = value[{digit, 2'b00} +: 4];

  always_comb begin
    font = 8'hFF;
    case (nib)
      4'h0: font = 8'hC0;
      4'h1: font = 8'hF9;
      4'h2: font = 8'hA4;
      4'h3: font = 8'hB0;
      4'h4: font = 8'h99;
      4'h5: font = 8'h92;
      4'h6: font = 8'h82;
      4'h7: font = 8'hF8;
      4'h8: font = 8'h80;
      4'h9: font = 8'h90;
      4'hA: font = 8'h88;
      4'hB: font = 8'h83;
      4'hC: font = 8'hC6;
      4'hD: font = 8'hA1;
      4'hE: font = 8'h86;
      default: font = 8'h8E;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      seg <= 8'hFF;
      sel <= 4'b1110;
    end else begin
      cnt <= cnt + 1'b1;
      seg <= font;
      sel <= ~(4'b0001 << digit);
    end
  end

endmodule

// File: rtl/cpu.sv
// Top of the 16-bit multi-cycle CPU: step FSM, ALU/branch unit and sub-module wiring.
module cpu
  import cpu_pkg::*;
#(
  parameter int unsigned IMEM_DEPTH = 256,
  parameter int unsigned DMEM_DEPTH = 256,
  parameter int unsigned SCAN_BITS  = 16
) (
  input  logic       board_ck,
  input  logic       rst,
  output logic       CLK,
  output logic       do_halt,
  output logic [7:0] SEG,
  output logic [3:0] SEG_SEL
);

  state_e      state_q, state_d;
  opcode_e     op;
  logic        step, halt_hit, fetch_en, decode_en, mem_en, reg_we, pc_we;
  logic        taken_q, taken_d;
  logic [7:0]  pc, pc_next, ea_q, ea_d;
  logic [15:0] instr, a_val, b_val, c_val, r1, rdata, alu_q, alu_d, wdata;

  // The core advances on the board_ck edge where CLK rises.
  assign step     = ~CLK;
  assign op       = f_op(instr);
  assign halt_hit = (instr == HALT_WORD);

  always_ff @(posedge board_ck or posedge rst) begin
    if (rst) begin
      CLK     <= 1'b0;
      do_halt <= 1'b1;
      state_q <= StFetch;
      alu_q   <= '0;
      taken_q <= 1'b0;
      ea_q    <= '0;
    end else begin
      CLK <= ~CLK;
      if (step) begin
        state_q <= state_d;
        if (state_q == StExec) begin
          alu_q   <= alu_d;
          taken_q <= taken_d;
          ea_q    <= ea_d;
          if (halt_hit) do_halt <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    alu_d   = '0;
    taken_d = 1'b0;
    ea_d    = b_val[7:0] + {4'b0000, f_c(instr)};
    case (op)
      OpAdd:   alu_d = b_val + c_val;
      OpSub:   alu_d = b_val - c_val;
      OpAnd:   alu_d = b_val & c_val;
      OpOr:    alu_d = b_val | c_val;
      OpAddi:  alu_d = a_val + sext8(f_imm8(instr));
      OpBeq:   taken_d = (a_val == b_val);
      OpBgt:   taken_d = ($signed(a_val) > $signed(b_val));
      default: ;
    endcase
    case (state_q)
      StFetch:  state_d = StDecode;
      StDecode: state_d = StExec;
      StExec:   state_d = halt_hit ? StHalted : StMem;
      StMem:    state_d = StWb;
      StWb:     state_d = StFetch;
      default:  state_d = StHalted;
    endcase
  end

  assign fetch_en  = step && (state_q == StFetch);
  assign decode_en = step && (state_q == StDecode);
  assign mem_en    = step && (state_q == StMem) && (op == OpLd || op == OpSt);
  assign reg_we    = step && (state_q == StWb) &&
                     (op inside {OpAdd, OpSub, OpAnd, OpOr, OpAddi, OpLd});
  assign wdata     = (op == OpLd) ? rdata : alu_q;
  assign pc_we     = step && (state_q == StWb);

  always_comb begin
    pc_next = pc + 8'd1;
    if (op == OpJmp)  pc_next = {f_b(instr), f_c(instr)};
    else if (taken_q) pc_next = pc + sext4(f_c(instr));
  end

  fetch_module #(.IMEM_DEPTH(IMEM_DEPTH)) u_fetch (
    .clk       (board_ck),
    .rst       (rst),
    .fetch_en  (fetch_en),
    .pc_we     (pc_we),
    .pc_next   (pc_next),
    .prog_we   (1'b0),
    .prog_addr (8'h00),
    .prog_data (16'h0000),
    .pc        (pc),
    .instr     (instr)
  );

  decode_module u_dec (
    .clk       (board_ck),
    .rst       (rst),
    .decode_en (decode_en),
    .ra        (f_a(instr)),
    .rb        (f_b(instr)),
    .rc        (f_c(instr)),
    .we        (reg_we),
    .waddr     (f_a(instr)),
    .wdata     (wdata),
    .a_val     (a_val),
    .b_val     (b_val),
    .c_val     (c_val),
    .r1        (r1)
  );

  memory_module #(.DMEM_DEPTH(DMEM_DEPTH)) u_mem (
    .clk    (board_ck),
    .mem_en (mem_en),
    .we     (op == OpSt),
    .addr   (ea_q),
    .wdata  (a_val),
    .rdata  (rdata)
  );

  seg7_driver #(.SCAN_BITS(SCAN_BITS)) u_seg (
    .clk   (board_ck),
    .rst   (rst),
    .value (r1),
    .seg   (SEG),
    .sel   (SEG_SEL)
  );

endmodule

// File: tb/tb_cpu.sv
// Bench for cpu: programs are preloaded, expected end state is queued and scored after HALT.
module tb_cpu;
  import cpu_pkg::*;

  logic       board_ck = 1'b0;
  logic       rst = 1'b1;
  logic       CLK, do_halt;
  logic [7:0] SEG;
  logic [3:0] SEG_SEL;

  cpu #(.IMEM_DEPTH(256), .DMEM_DEPTH(256), .SCAN_BITS(4)) dut (
    .board_ck (board_ck),
    .rst      (rst),
    .CLK      (CLK),
    .do_halt  (do_halt),
    .SEG      (SEG),
    .SEG_SEL  (SEG_SEL)
  );

  always #5 board_ck = ~board_ck;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // kind: 0 = register, 1 = data memory word, 2 = PC
  typedef struct {
    string       tag;
    int          kind;
    int          idx;
    logic [15:0] val;
  } exp_t;

  exp_t        sb[$];
  logic [11:0] disp_sb[$];
  logic [15:0] prog[$];

  task automatic expect_val(input string tag, input int kind, input int idx,
                            input logic [15:0] val);
    exp_t e;
    e.tag  = tag;
    e.kind = kind;
    e.idx  = idx;
    e.val  = val;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t        e;
    logic [15:0] got;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.kind)
        0:       got = dut.u_dec.regs[e.idx];
        1:       got = dut.u_mem.memory[e.idx];
        default: got = {8'h00, dut.u_fetch.pc};
      endcase
      check(e.tag, got, e.val);
    end
  endtask

  // Asserts reset, clears both memories and loads prog into IMEM; reset stays asserted.
  task automatic hold_reset();
    rst = 1'b1;
    @(negedge board_ck);
    for (int i = 0; i < 256; i++) begin
      dut.u_fetch.memory[i] <= (i < prog.size()) ? prog[i] : 16'h0000;
      dut.u_mem.memory[i]   <= 16'h0000;
    end
  endtask

  task automatic release_reset();
    @(negedge board_ck);
    rst = 1'b0;
  endtask

  task automatic run_to_halt(input string tag, input int budget);
    int n = 0;
    while (do_halt === 1'b1 && n < budget) begin
      @(negedge board_ck);
      n++;
    end
    check({tag, "_halted"}, {15'b0, do_halt}, 16'h0000);
  endtask

  initial begin
    int          halt_at;
    int          n;
    logic [15:0] src [5];
    logic [11:0] d;
    logic [3:0]  prev_sel;

    // 1. Reset values, CLK toggling, immediate HALT.
    prog = '{16'hFFFF};
    hold_reset();
    @(negedge board_ck);
    check("rst_pc", {8'h00, dut.u_fetch.pc}, 16'h0000);
    check("rst_do_halt", {15'b0, do_halt}, 16'h0001);
    check("rst_clk", {15'b0, CLK}, 16'h0000);
    check("rst_seg_sel", {12'h000, SEG_SEL}, 16'h000E);
    check("rst_seg", {8'h00, SEG}, 16'h00FF);
    release_reset();
    halt_at = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge board_ck);
      if (k <= 4) check("clk_toggle", {15'b0, CLK}, (k % 2 == 1) ? 16'h0001 : 16'h0000);
      if (do_halt === 1'b0 && halt_at == 0) halt_at = k;
    end
    check("halt_latency", 16'(halt_at), 16'd5);
    repeat (20) @(negedge board_ck);
    check("halted_pc", {8'h00, dut.u_fetch.pc}, 16'h0000);
    check("halted_stays", {15'b0, do_halt}, 16'h0000);

    // 2a. ADDI with negative immediate.
    prog = '{16'h5102, 16'h51FF, 16'hFFFF};
    hold_reset();
    release_reset();
    expect_val("addi_r1", 0, 1, 16'h0001);
    expect_val("addi_pc", 2, 0, 16'h0002);
    run_to_halt("addi", 400);
    drain();

    // 2b. ADDI carries across byte and wraps at 16 bits.
    prog = '{16'h517F, 16'h5101, 16'h52FF, 16'h5201, 16'h53FF, 16'hFFFF};
    hold_reset();
    release_reset();
    expect_val("wrap_r1", 0, 1, 16'h0080);
    expect_val("wrap_r2", 0, 2, 16'h0000);
    expect_val("wrap_r3", 0, 3, 16'hFFFF);
    run_to_halt("wrap", 400);
    drain();

    // 3. Copy loop with backward BGT.
    prog = '{16'h0000, 16'h5102, 16'h520A, 16'h5307, 16'h9410, 16'hA420,
             16'h5101, 16'h5201, 16'hD31C, 16'h0000, 16'hFFFF};
    src  = '{16'd6, 16'd4, 16'd3, 16'd2, 16'd5};
    hold_reset();
    for (int i = 0; i < 5; i++) begin
      dut.u_mem.memory[2 + i] <= src[i];
      expect_val("copy_dst", 1, 10 + i, src[i]);
    end
    expect_val("copy_after", 1, 15, 16'h0000);
    expect_val("copy_r1", 0, 1, 16'd7);
    expect_val("copy_r2", 0, 2, 16'd15);
    expect_val("copy_r3", 0, 3, 16'd7);
    expect_val("copy_r4", 0, 4, 16'd5);
    expect_val("copy_pc", 2, 0, 16'd10);
    release_reset();
    run_to_halt("copy", 3000);
    drain();

    // 4. BEQ taken/untaken, BGT signed both ways, JMP.
    prog = '{16'h5305, 16'h5405, 16'hC342, 16'h5A01, 16'h5B01, 16'h53FA, 16'hD312,
             16'h5C01, 16'hC432, 16'h5D01, 16'hD132, 16'h5E01, 16'hE00E, 16'h5F01,
             16'hFFFF};
    hold_reset();
    release_reset();
    expect_val("beq_taken_skip", 0, 10, 16'h0000);
    expect_val("beq_taken_dst", 0, 11, 16'h0001);
    expect_val("neg_r3", 0, 3, 16'hFFFF);
    expect_val("bgt_neg_untaken", 0, 12, 16'h0001);
    expect_val("beq_untaken", 0, 13, 16'h0001);
    expect_val("bgt_taken_skip", 0, 14, 16'h0000);
    expect_val("jmp_skip", 0, 15, 16'h0000);
    expect_val("branch_pc", 2, 0, 16'd14);
    run_to_halt("branch", 1000);
    drain();

    // 5. Reset during MEM of a store aborts it.
    prog = '{16'h5103, 16'h5209, 16'hA120, 16'hFFFF};
    hold_reset();
    release_reset();
    n = 0;
    while (!(dut.state_q == StMem && dut.u_fetch.pc == 8'd2) && n < 400) begin
      @(negedge board_ck);
      n++;
    end
    check("st_reached_mem", {15'b0, dut.state_q == StMem}, 16'h0001);
    rst = 1'b1;
    repeat (2) @(negedge board_ck);
    check("abort_dmem", dut.u_mem.memory[9], 16'h0000);
    check("abort_pc", {8'h00, dut.u_fetch.pc}, 16'h0000);
    check("abort_do_halt", {15'b0, do_halt}, 16'h0001);
    check("abort_r1", dut.u_dec.regs[1], 16'h0000);
    check("abort_state", {13'b0, dut.state_q}, {13'b0, StFetch});
    rst = 1'b0;
    expect_val("st_rerun", 1, 9, 16'h0003);
    run_to_halt("st", 400);
    drain();

    // 6. Display scan of r1 = 16'h1A2F, continuing after halt.
    prog = '{16'hFFFF};
    hold_reset();
    release_reset();
    run_to_halt("disp", 100);
    dut.u_dec.regs[1] <= 16'h1A2F;
    disp_sb = '{{4'b1110, 8'h8E}, {4'b1101, 8'hA4}, {4'b1011, 8'h88}, {4'b0111, 8'hF9},
                {4'b1110, 8'h8E}};
    repeat (80) @(negedge board_ck);
    n = 0;
    while (SEG_SEL !== 4'b0111 && n < 200) begin
      @(negedge board_ck);
      n++;
    end
    check("disp_sync", {12'h000, SEG_SEL}, 16'h0007);
    while (disp_sb.size() > 0) begin
      prev_sel = SEG_SEL;
      n = 0;
      while (SEG_SEL === prev_sel && n < 40) begin
        @(negedge board_ck);
        n++;
      end
      d = disp_sb.pop_front();
      check("disp_sel", {12'h000, SEG_SEL}, {12'h000, d[11:8]});
      check("disp_seg", {8'h00, SEG}, {8'h00, d[7:0]});
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
